converter_66b_to_64b: RTL and testbench

- Transmit-side gearbox for the 64b/66b PCS. It sits between the 64b/66b encoder/scrambler output (66-bit blocks, sync header in bits [1:0]) and the 64-bit PMA/SerDes interface.
- It packs a continuous stream of 66-bit blocks into 64-bit words, LSB first, with no gaps or padding.
- Every 32 input blocks produce exactly 33 output words. The input is therefore back-pressured for one cycle in every 33 output beats.

---
 rtl/converter_66b_to_64b.sv | 42 ++++
 tb/tb_converter_66b_to_64b.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/converter_66b_to_64b.sv
// converter_66b_to_64b: packs a stream of 66-bit PCS blocks into 64-bit PMA words, LSB first
module converter_66b_to_64b (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);
  logic [5:0]   ptr;
  logic [63:0]  residual;
  logic [127:0] cat;
  logic         adv, take, flush;
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv && ptr != 6'd32 && !reset;
  assign take          = s_axis_tvalid && s_axis_tready;
  assign flush         = adv && ptr == 6'd32;
  // new block lands directly above the 2*ptr leftover bits
  assign cat = ({62'd0, s_axis_tdata} << {ptr, 1'b0}) |
               {64'd0, residual & ((64'd1 << {ptr, 1'b0}) - 64'd1)};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr           <= '0;
      residual      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (take) begin
      m_axis_tdata  <= cat[63:0];
      m_axis_tvalid <= 1'b1;
      residual      <= cat[127:64];
      ptr           <= ptr + 6'd1;
    end else if (flush) begin
      m_axis_tdata  <= residual;
      m_axis_tvalid <= 1'b1;
      residual      <= '0;
      ptr           <= '0;
    end else if (adv) begin
      m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_converter_66b_to_64b.sv
// tb_converter_66b_to_64b: directed vectors plus a bit-queue scoreboard for the 66b->64b gearbox
module tb_converter_66b_to_64b;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [65:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  int          n_chk = 0, n_pass = 0, n_words = 0, n_acc = 0;
  bit          q[$];
  converter_66b_to_64b dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mdata", m_axis_tdata, 64'd0);
    check("rst_sready", 64'(s_axis_tready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    n_words = 0;
    n_acc = 0;
  endtask
  // one clock: record handshakes before the edge, score the departing word after it
  task automatic tick();
    logic a, o, st;
    logic [63:0] d, e;
    #2;
    a  = s_axis_tvalid && s_axis_tready;
    o  = m_axis_tvalid && m_axis_tready;
    st = m_axis_tvalid && !m_axis_tready;
    d  = m_axis_tdata;
    if (a) begin
      for (int i = 0; i < 66; i++) q.push_back(s_axis_tdata[i]);
      n_acc++;
    end
    @(posedge clk); #1;
    if (o) begin
      n_words++;
      for (int i = 0; i < 64; i++) e[i] = q.size() > 0 ? q.pop_front() : ~d[i];
      check("stream", d, e);
    end
    if (st) check("hold", m_axis_tdata, d);
  endtask
  initial begin
    logic [95:0] r;
    int cyc;
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 66'h3_0000_0000_0000_0001;
    tick();
    check("w0_data", m_axis_tdata, 64'h0000_0000_0000_0001);
    check("w0_valid", 64'(m_axis_tvalid), 64'd1);
    s_axis_tdata = 66'h0;
    tick();
    check("w1_data", m_axis_tdata, 64'h0000_0000_0000_0003);
    s_axis_tvalid = 1'b0;
    tick();
    check("idle_valid", 64'(m_axis_tvalid), 64'd0);
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = '1;
    for (int k = 0; k < 33; k++) begin
      #1;
      check("ones_ready", 64'(s_axis_tready), 64'(k != 32));
      tick();
      check("ones_data", m_axis_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ones_valid", 64'(m_axis_tvalid), 64'd1);
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("ones_no34", 64'(m_axis_tvalid), 64'd0);
    check("ones_words", 64'(n_words), 64'd33);
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_axis_tdata = k == 16 ? {34'h3_FFFF_FFFF, 32'h0} : 66'h0;
      tick();
    end
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("gap_valid", 64'(m_axis_tvalid), 64'd0);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 66'h0;
    tick();
    check("gap_resid", m_axis_tdata, 64'h0000_0003_FFFF_FFFF);
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      s_axis_tdata = k == 31 ? {64'hDEAD_BEEF_CAFE_F00D, 2'b01} : 66'h0;
      tick();
    end
    m_axis_tready = 1'b0;
    s_axis_tdata = 66'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 64'(s_axis_tready), 64'd0);
      tick();
      check("stall_data", m_axis_tdata, 64'h4000_0000_0000_0000);
      check("stall_valid", 64'(m_axis_tvalid), 64'd1);
    end
    m_axis_tready = 1'b1;
    #1;
    check("flush_ready", 64'(s_axis_tready), 64'd0);
    tick();
    check("flush_data", m_axis_tdata, 64'hDEAD_BEEF_CAFE_F00D);
    #1;
    check("wrap_ready", 64'(s_axis_tready), 64'd1);
    s_axis_tvalid = 1'b0;
    tick();
    do_reset();
    cyc = 0;
    while (n_acc < 200 && cyc < 5000) begin
      r = {$urandom(), $urandom(), $urandom()};
      s_axis_tdata = r[65:0];
      s_axis_tvalid = 1'($urandom_range(0, 1));
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("rnd_accepted", 64'(n_acc), 64'd200);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("rnd_words", 64'(n_words), 64'd206);
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = '1;
    for (int k = 0; k < 9; k++) tick();
    check("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 66'h1_FFFF_FFFF_FFFF_FFFD;
    tick();
    check("post_rst_data", m_axis_tdata, 64'hFFFF_FFFF_FFFF_FFFD);
    check("post_rst_valid", 64'(m_axis_tvalid), 64'd1);
    s_axis_tvalid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
